rcvr_frame_fifo: RTL and testbench
==================================

// Module: rcvr_frame_fifo
// PURPOSE
//  Parametrised serial frame receiver. Hunts a bit stream for a HEAD_WIDTH-bit sync pattern.
//  Captures the next DATA_WIDTH bits, MSB first, then an optional even-parity bit.
//  Buffers completed words in a FIFO_DEPTH-deep show-ahead FIFO.
//  Sits between the serial line sampler and the host read port; absorbs host read latency.
// PARAMETERS
//  HEAD_WIDTH  8      sync pattern width, >=2
//  MATCH       8'hA5  sync pattern, MSB received first
//  DATA_WIDTH  8      payload bits per frame, >=2
//  FIFO_DEPTH  4      FIFO entries, power of 2, >=2
//  PARITY_EN   0      1: one even-parity bit follows the payload
// PORTS
//  clock       in   1                      rising-edge clock, one data_in bit sampled per edge
//  reset_n     in   1                      asynchronous active-low reset
//  data_in     in   1                      serial data bit
//  enable      in   1                      receiver enable; 0 aborts any partial frame
//  reading     in   1                      host pops FIFO head this cycle
//  ready       out  1                      FIFO non-empty; data_out valid
//  data_out    out  DATA_WIDTH             FIFO head word (show-ahead)
//  level       out  $clog2(FIFO_DEPTH+1)   FIFO occupancy
//  overrun     out  1                      sticky: a completed word was dropped because the FIFO was full
//  parity_err  out  1                      one-cycle pulse: frame discarded on parity mismatch
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream) sets:
//   - state=HUNT, count=0, FIFO empty
//   - ready=0, level=0, overrun=0, parity_err=0, data_out=0
//   - head register = HEAD_WIDTH-1 copies of ~MATCH[HEAD_WIDTH-1], so there is no false match from reset
//  FSM states: HUNT, BODY, PAR. All transitions are gated by enable=1.
//  enable=0: state->HUNT, head reset, count=0, partial word discarded. FIFO, overrun and reads are unaffected.
//  HUNT: head <= {head, data_in}. If {head, data_in}==MATCH then ->BODY, count=0.
//   - Overlapping matches are legal (e.g. pattern 0101 at the tail of prior data).
//  BODY: body <= {body, data_in}, count++. The head register is held at its reset value.
//   - No re-sync on MATCH inside the body.
//   - When count==DATA_WIDTH-1, word = {body, data_in}:
//     - PARITY_EN=0: push word, ->HUNT, count=0.
//     - PARITY_EN=1: ->PAR.
//  PAR: if ^{word, data_in}==0, push word; else parity_err=1 for this edge only, no push. Then ->HUNT.
//  Latency: ready rises on the edge that samples the last frame bit, when the FIFO was empty.
//   - Back-to-back frames are allowed: HUNT starts the cycle after the last bit.
//  FIFO is show-ahead: data_out = head entry whenever ready=1.
//   - data_out holds its last value when empty.
//  reading=1 with ready=1 pops the head. reading=1 with ready=0 is ignored (no underflow, level stays 0).
//  Push and pop on the same edge: both take effect and level is unchanged, including when full.
//  Push when full without pop: word dropped, FIFO untouched, overrun<=1.
//  overrun is cleared by any edge with reading=1. That clear takes priority; a drop is impossible on a pop edge.
//  level width is $clog2(FIFO_DEPTH+1); pointers wrap modulo FIFO_DEPTH.
//  Reset mid-frame or with a full FIFO returns to the reset state immediately (async).
// STRUCTURE
//  Package rcvr_pkg holds:
//   - state encodings HUNT/BODY/PAR
//   - helper function clog2
//  Sub-module rcvr_fifo: sync show-ahead FIFO with params WIDTH and DEPTH.
//   - Ports: push, wdata, pop, rdata, empty, full, level.
//  Top level holds the FSM, head/body shift registers, count, parity and overrun logic.
// TESTING
//  1. Defaults, stream 1010_0101 then 0011_1100:
//     ready rises on the 16th edge, data_out=8'h3C, level=1. reading -> ready=0.
//  2. Five back-to-back A5+payload frames, reading=0, depth 4:
//     level=4 after frame 4; frame 5 sets overrun=1 and is dropped.
//     Pop order is payloads 1-4; the first reading clears overrun.
//  3. FIFO full, frame 5 completes on the same edge as reading=1:
//     no overrun, level stays 4, the 5th payload is last out.
//  4. PARITY_EN=1, A5+8'h81+par 0: word pushed.
//     A5+8'h81+par 1: parity_err pulses 1 cycle, level unchanged.
//  5. enable dropped after 3 body bits, then resent A5+8'h5A:
//     only 8'h5A is received. reset_n pulse mid-frame: all outputs 0 asynchronously.
//  6. Stream 1010_1001_01+payload (overlap):
//     match is found at the correct offset; reading while empty leaves level=0.

Source files
------------

// File: rtl/rcvr_pkg.sv
// Shared definitions for the serial frame receiver: FSM state codes and a width helper.
package rcvr_pkg;

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  // Bits needed to index v distinct values.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rcvr_fifo.sv
// Synchronous show-ahead FIFO; rdata is a register that always holds the head entry
// while non-empty and keeps its last value once drained.
module rcvr_fifo
  import rcvr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          empty,
  output logic                          full,
  output logic [clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pop_ok, we;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == LW'(DEPTH));
  assign pop_ok = pop & ~empty;
  assign we     = push & (~full | pop_ok);

  // Next head: the entry being written bypasses the array when it becomes the head.
  always_comb begin
    rd_d    = rd_q + AW'(pop_ok);
    wr_d    = wr_q + AW'(we);
    cnt_d   = cnt_q + LW'(we) - LW'(pop_ok);
    rdata_d = rdata_q;
    if (cnt_d != '0) begin
      rdata_d = (we && (rd_d == wr_q)) ? wdata : mem_q[rd_d];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[wr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign level = cnt_q;

endmodule

// File: rtl/rcvr_frame_fifo.sv
// Serial frame receiver: hunts for a sync pattern, captures an MSB-first payload with
// optional even parity, and buffers completed words in a show-ahead FIFO.
module rcvr_frame_fifo
  import rcvr_pkg::*;
#(
  parameter int unsigned                HEAD_WIDTH = 8,
  parameter logic [HEAD_WIDTH-1:0]      MATCH      = 8'hA5,
  parameter int unsigned                DATA_WIDTH = 8,
  parameter int unsigned                FIFO_DEPTH = 4,
  parameter int unsigned                PARITY_EN  = 0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               data_in,
  input  logic                               enable,
  input  logic                               reading,
  output logic                               ready,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic                               overrun,
  output logic                               parity_err
);

  localparam int unsigned HW1 = HEAD_WIDTH - 1;
  localparam int unsigned CW  = clog2(DATA_WIDTH);
  // Inverted sync MSB everywhere: no match is possible until HEAD_WIDTH fresh bits arrive.
  localparam logic [HEAD_WIDTH-2:0] HEAD_RST = {HW1{~MATCH[HEAD_WIDTH-1]}};

  logic [1:0]            state_q, state_d;
  logic [HEAD_WIDTH-2:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] body_q, body_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  perr_q, perr_d;
  logic                  ovr_q, ovr_d;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] word_c, wdata_c;
  logic                  fifo_empty, fifo_full;

  assign word_c  = {body_q[DATA_WIDTH-2:0], data_in};
  assign wdata_c = (state_q == PAR) ? body_q : word_c;

  // Frame FSM and shift registers.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    body_d  = body_q;
    count_d = count_q;
    push_c  = 1'b0;
    perr_d  = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      head_d  = HEAD_RST;
      count_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          head_d = HW1'({head_q, data_in});
          if ({head_q, data_in} == MATCH) begin
            state_d = BODY;
            head_d  = HEAD_RST;
            count_d = '0;
          end
        end
        BODY: begin
          head_d  = HEAD_RST;
          body_d  = word_c;
          count_d = count_q + CW'(1);
          if (count_q == CW'(DATA_WIDTH - 1)) begin
            count_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PAR;
            end else begin
              state_d = HUNT;
              push_c  = 1'b1;
            end
          end
        end
        PAR: begin
          head_d  = HEAD_RST;
          state_d = HUNT;
          if (^{body_q, data_in}) perr_d = 1'b1;
          else                    push_c = 1'b1;
        end
        default: begin
          state_d = HUNT;
          head_d  = HEAD_RST;
          count_d = '0;
        end
      endcase
    end
  end

  // A read edge always clears; a full FIFO with reading=1 pops, so it cannot drop too.
  always_comb begin
    ovr_d = ovr_q;
    if (reading)                 ovr_d = 1'b0;
    else if (push_c & fifo_full) ovr_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      head_q  <= HEAD_RST;
      body_q  <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      body_q  <= body_d;
      count_q <= count_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  rcvr_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_c),
    .wdata   (wdata_c),
    .pop     (reading),
    .rdata   (data_out),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  assign ready      = ~fifo_empty;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_rcvr_frame_fifo.sv
// Bench for rcvr_frame_fifo: one default instance and one with parity enabled, each
// shadowed by a bit-history / list-based reference model.
module tb_rcvr_frame_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din, en, rd;
  logic [1:0] rdy, ovr, perr;
  logic [7:0] dout0, dout1;
  logic [2:0] lvl0, lvl1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rcvr_frame_fifo #(.HEAD_WIDTH(8), .MATCH(8'hA5), .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(0)) u_dut (
    .clock(clk), .reset_n(rst_n), .data_in(din[0]), .enable(en[0]), .reading(rd[0]),
    .ready(rdy[0]), .data_out(dout0), .level(lvl0), .overrun(ovr[0]), .parity_err(perr[0]));

  rcvr_frame_fifo #(.HEAD_WIDTH(8), .MATCH(8'hA5), .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(1)) u_dutp (
    .clock(clk), .reset_n(rst_n), .data_in(din[1]), .enable(en[1]), .reading(rd[1]),
    .ready(rdy[1]), .data_out(dout1), .level(lvl1), .overrun(ovr[1]), .parity_err(perr[1]));

  // Reference model state, index 0 = plain, 1 = parity instance.
  bit          m_hunt [2];
  int          m_nh   [2];
  logic [31:0] m_hv   [2];
  logic [31:0] m_pv   [2];
  int          m_np   [2];
  logic [7:0]  m_q    [2][4];
  int          m_n    [2];
  bit          m_ovr  [2];
  bit          m_perr [2];
  logic [7:0]  m_dout [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hunt[k] = 1'b1; m_nh[k] = 0; m_hv[k] = '0; m_pv[k] = '0; m_np[k] = 0;
      m_n[k] = 0; m_ovr[k] = 1'b0; m_perr[k] = 1'b0; m_dout[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    logic [7:0] word;
    bit push, drop;
    push = 1'b0; drop = 1'b0; word = '0;
    m_perr[k] = 1'b0;
    if (!en[k]) begin
      m_hunt[k] = 1'b1; m_nh[k] = 0; m_hv[k] = '0;
    end else if (m_hunt[k]) begin
      m_hv[k] = {m_hv[k][30:0], din[k]};
      m_nh[k]++;
      if (m_nh[k] >= 8 && m_hv[k][7:0] == 8'hA5) begin
        m_hunt[k] = 1'b0; m_np[k] = 0; m_pv[k] = '0;
      end
    end else begin
      m_pv[k] = {m_pv[k][30:0], din[k]};
      m_np[k]++;
      if (m_np[k] == 8 + k) begin
        m_hunt[k] = 1'b1; m_nh[k] = 0; m_hv[k] = '0;
        if (k == 1) begin
          word = m_pv[k][8:1];
          if (^m_pv[k][8:0]) m_perr[k] = 1'b1;
          else               push = 1'b1;
        end else begin
          word = m_pv[k][7:0];
          push = 1'b1;
        end
      end
    end
    if (rd[k] && m_n[k] > 0) begin
      for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
      m_n[k]--;
    end
    if (push) begin
      if (m_n[k] < 4) begin
        m_q[k][m_n[k]] = word;
        m_n[k]++;
      end else begin
        drop = 1'b1;
      end
    end
    if (rd[k])     m_ovr[k] = 1'b0;
    else if (drop) m_ovr[k] = 1'b1;
    if (m_n[k] > 0) m_dout[k] = m_q[k][0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic send(input int k, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din[k] = v[i];
      tick();
    end
    din[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din = '0; en = '0; rd = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rdy, ovr, perr, lvl0, lvl1} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0", {rdy, ovr, perr, lvl0, lvl1});
    end
    n_checks++;
    if ({dout0, dout1} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0000", {dout0, dout1});
    end
  endtask

  task automatic test_basic();
    logic [15:0] s;
    do_reset();
    s = 16'hA53C;
    en[0] = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      din[0] = s[i];
      tick();
      n_checks++;
      if (rdy[0] !== (i == 0)) begin
        n_fail++;
        $display("FAIL basic_ready_edge%0d: got %b required %b", 16 - i, rdy[0], (i == 0));
      end
    end
    n_checks++;
    if (dout0 !== 8'h3C || lvl0 !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_word: got data %h level %0d required 3c level 1", dout0, lvl0);
    end
    rd[0] = 1'b1; tick(); rd[0] = 1'b0;
    n_checks++;
    if (rdy[0] !== 1'b0 || lvl0 !== 3'd0 || dout0 !== 8'h3C) begin
      n_fail++;
      $display("FAIL basic_pop: got ready %b level %0d data %h required 0 0 3c", rdy[0], lvl0, dout0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] p [5];
    do_reset();
    en[0] = 1'b1;
    for (int f = 0; f < 5; f++) p[f] = 8'($urandom);
    for (int f = 0; f < 5; f++) begin
      send(0, {16'h0, 8'hA5, p[f]}, 16);
      if (f == 3) begin
        n_checks++;
        if (lvl0 !== 3'd4 || ovr[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_fill: got level %0d overrun %b required 4 0", lvl0, ovr[0]);
        end
      end
    end
    n_checks++;
    if (lvl0 !== 3'd4 || ovr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drop: got level %0d overrun %b required 4 1", lvl0, ovr[0]);
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (dout0 !== p[j]) begin
        n_fail++;
        $display("FAIL ovr_order%0d: got %h required %h", j, dout0, p[j]);
      end
      rd[0] = 1'b1; tick(); rd[0] = 1'b0;
      if (j == 0) begin
        n_checks++;
        if (ovr[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_clear: got %b required 0", ovr[0]);
        end
      end
    end
    n_checks++;
    if (lvl0 !== 3'd0) begin
      n_fail++;
      $display("FAIL ovr_drain: got level %0d required 0", lvl0);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] p [5];
    logic [15:0] fr;
    do_reset();
    en[0] = 1'b1;
    for (int f = 0; f < 5; f++) p[f] = 8'($urandom);
    for (int f = 0; f < 4; f++) send(0, {16'h0, 8'hA5, p[f]}, 16);
    fr = {8'hA5, p[4]};
    send(0, {17'h0, fr[15:1]}, 15);
    din[0] = fr[0]; rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0; din[0] = 1'b0;
    n_checks++;
    if (ovr[0] !== 1'b0 || lvl0 !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_level: got overrun %b level %0d required 0 4", ovr[0], lvl0);
    end
    for (int j = 1; j < 5; j++) begin
      n_checks++;
      if (dout0 !== p[j]) begin
        n_fail++;
        $display("FAIL fullpop_order%0d: got %h required %h", j, dout0, p[j]);
      end
      rd[0] = 1'b1; tick(); rd[0] = 1'b0;
    end
    n_checks++;
    if (lvl0 !== 3'd0) begin
      n_fail++;
      $display("FAIL fullpop_drain: got level %0d required 0", lvl0);
    end
  endtask

  task automatic test_parity();
    do_reset();
    en[1] = 1'b1;
    send(1, {15'h0, 8'hA5, 8'h81, 1'b0}, 17);
    n_checks++;
    if (lvl1 !== 3'd1 || dout1 !== 8'h81 || perr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL par_good: got level %0d data %h perr %b required 1 81 0", lvl1, dout1, perr[1]);
    end
    send(1, {15'h0, 8'hA5, 8'h81, 1'b1}, 17);
    n_checks++;
    if (perr[1] !== 1'b1 || lvl1 !== 3'd1) begin
      n_fail++;
      $display("FAIL par_bad: got perr %b level %0d required 1 1", perr[1], lvl1);
    end
    tick();
    n_checks++;
    if (perr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL par_pulse: got %b required 0", perr[1]);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en[0] = 1'b1;
    send(0, 32'hA5, 8);
    send(0, 32'h5, 3);
    en[0] = 1'b0; din[0] = 1'b1;
    tick();
    en[0] = 1'b1;
    send(0, 32'hA55A, 16);
    n_checks++;
    if (lvl0 !== 3'd1 || dout0 !== 8'h5A) begin
      n_fail++;
      $display("FAIL enable_abort: got level %0d data %h required 1 5a", lvl0, dout0);
    end
    send(0, 32'hA5, 8);
    send(0, 32'h6, 3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy[0] !== 1'b0 || lvl0 !== 3'd0 || dout0 !== 8'h0 || ovr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ready %b level %0d data %h ovr %b required all 0", rdy[0], lvl0, dout0, ovr[0]);
    end
    #2;
    model_reset();
    en = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [7:0] pay;
    do_reset();
    en[0] = 1'b1;
    pay = 8'($urandom);
    send(0, 32'b10_1010_0101, 10);
    send(0, {24'h0, pay}, 8);
    n_checks++;
    if (lvl0 !== 3'd1 || dout0 !== pay) begin
      n_fail++;
      $display("FAIL overlap_word: got level %0d data %h required 1 %h", lvl0, dout0, pay);
    end
    rd[0] = 1'b1; tick(); tick(); rd[0] = 1'b0;
    n_checks++;
    if (lvl0 !== 3'd0 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: got level %0d ready %b required 0 0", lvl0, rdy[0]);
    end
  endtask

  task automatic test_random();
    bit pend0[$], pend1[$];
    logic [31:0] seg;
    logic [7:0]  pay;
    int          len;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && pend0.size() == 0) || (k == 1 && pend1.size() == 0)) begin
          if ($urandom_range(0, 9) < 6) begin
            pay = 8'($urandom);
            if (k == 1) begin
              seg = 32'({8'hA5, pay, (^pay) ^ ($urandom_range(0, 4) == 0)});
              len = 17;
            end else begin
              seg = 32'({8'hA5, pay});
              len = 16;
            end
          end else begin
            seg = $urandom;
            len = $urandom_range(1, 6);
          end
          for (int i = len - 1; i >= 0; i--) begin
            if (k == 0) pend0.push_back(seg[i]);
            else        pend1.push_back(seg[i]);
          end
        end
      end
      din[0] = pend0.pop_front();
      din[1] = pend1.pop_front();
      en[0]  = ($urandom_range(0, 59) != 0);
      en[1]  = ($urandom_range(0, 59) != 0);
      rd[0]  = ($urandom_range(0, 3) == 0);
      rd[1]  = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if ({rdy[0], lvl0, dout0, ovr[0], perr[0]} !== {m_n[0] != 0, 3'(m_n[0]), m_dout[0], m_ovr[0], m_perr[0]}) begin
        n_fail++;
        $display("FAIL rand_plain cyc%0d: got rdy %b lvl %0d data %h ovr %b perr %b required %b %0d %h %b %b",
                 c, rdy[0], lvl0, dout0, ovr[0], perr[0], m_n[0] != 0, m_n[0], m_dout[0], m_ovr[0], m_perr[0]);
      end
      n_checks++;
      if ({rdy[1], lvl1, dout1, ovr[1], perr[1]} !== {m_n[1] != 0, 3'(m_n[1]), m_dout[1], m_ovr[1], m_perr[1]}) begin
        n_fail++;
        $display("FAIL rand_parity cyc%0d: got rdy %b lvl %0d data %h ovr %b perr %b required %b %0d %h %b %b",
                 c, rdy[1], lvl1, dout1, ovr[1], perr[1], m_n[1] != 0, m_n[1], m_dout[1], m_ovr[1], m_perr[1]);
      end
    end
    en = '0; rd = '0; din = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; din = '0; en = '0; rd = '0;
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_full_pop();
    test_parity();
    test_enable();
    test_overlap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
